// File: rtl/z80_cmd_port_if.sv
// Z80 wrapper I/O bus as seen by a peripheral: address, data both ways, strobes and interrupt requests.
// The master side is the Z80 wrapper; the slave side is the responding peripheral.
interface z80_cmd_port_if;
  logic [15:0] adr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        rd;
  logic        wr;
  logic        iw;
  logic        ir;
  logic        intreq;
  logic        nmireq;

  modport master (
    output adr, cpu_dout, rd, wr, iw, ir,
    input  cpu_din, intreq, nmireq
  );

  modport slave (
    input  adr, cpu_dout, rd, wr, iw, ir,
    output cpu_din, intreq, nmireq
  );
endinterface

// File: rtl/z80_cmd_port.sv
// Host<->Z80 command/reply port with status/control register and periodic NMI timer.
// Strobe actions take effect one clk after the strobe rising edge; define CMD_FIFO_EN for a 4-deep command FIFO.
module z80_cmd_port #(
  parameter logic [7:0]  CMD_PORT  = 8'h00,
  parameter logic [7:0]  CTL_PORT  = 8'h01,
  parameter logic [15:0] TIMER_DIV = 16'd10000,
  parameter logic [7:0]  NMI_WIDTH = 8'd8
) (
  input  logic           clk,
  input  logic           reset_n,
  z80_cmd_port_if.slave  bus,
  input  logic           host_wr,
  input  logic [7:0]     host_data,
  output logic           host_busy,
  output logic [7:0]     host_reply
);

  logic        iw_q, ir_q;
  logic        iw_edge, ir_edge, ir_fall;
  logic        cmd_sel, ctl_sel;
  logic        cmd_rd, cmd_wr, ctl_wr;
  logic        pending, overrun;
  logic [7:0]  cmd_dat;
  logic        nmi_en, nmireq_q, tmr_wrap;
  logic [15:0] tmr_cnt;
  logic [7:0]  nmi_cnt;
  logic        unused_ok;

  assign unused_ok = ^{bus.rd, bus.wr, bus.adr[15:8]};

  assign iw_edge = bus.iw & ~iw_q;
  assign ir_edge = bus.ir & ~ir_q;
  assign ir_fall = ir_q & ~bus.ir;
  assign cmd_sel = (bus.adr[7:0] == CMD_PORT);
  assign ctl_sel = (bus.adr[7:0] == CTL_PORT);
  assign cmd_rd  = ir_edge & cmd_sel;
  assign cmd_wr  = iw_edge & cmd_sel;
  assign ctl_wr  = iw_edge & ctl_sel;

`ifdef CMD_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       pop_armed, push, pop;

  // The head is popped only when the read strobe falls, so cpu_din stays stable for the whole access.
  assign pop  = ir_fall & pop_armed & (count != 3'd0);
  assign push = host_wr & ((count != 3'd4) | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      count     <= 3'd0;
      pop_armed <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (cmd_rd)       pop_armed <= 1'b1;
      else if (ir_fall) pop_armed <= 1'b0;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (host_wr && !push) overrun <= 1'b1;
      else if (cmd_rd)      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= host_data;
  end

  assign pending   = (count != 3'd0);
  assign host_busy = (count == 3'd4);
  assign cmd_dat   = fifo_mem[rd_ptr];
`else
  logic [7:0] cmd_latch;
  logic       pending_q;

  // A host write coincident with the acknowledging read wins: the new byte stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_latch <= 8'h00;
      pending_q <= 1'b0;
      overrun   <= 1'b0;
    end else if (host_wr) begin
      cmd_latch <= host_data;
      pending_q <= 1'b1;
      overrun   <= cmd_rd ? 1'b0 : (overrun | pending_q);
    end else if (cmd_rd) begin
      pending_q <= 1'b0;
      overrun   <= 1'b0;
    end
  end

  assign pending   = pending_q;
  assign host_busy = pending_q;
  assign cmd_dat   = cmd_latch;
`endif

  assign tmr_wrap = (tmr_cnt == TIMER_DIV - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iw_q       <= 1'b0;
      ir_q       <= 1'b0;
      host_reply <= 8'h00;
      nmi_en     <= 1'b0;
      tmr_cnt    <= 16'd0;
      nmi_cnt    <= 8'd0;
      nmireq_q   <= 1'b0;
    end else begin
      iw_q <= bus.iw;
      ir_q <= bus.ir;
      if (cmd_wr) host_reply <= bus.cpu_dout;
      if (ctl_wr) nmi_en <= bus.cpu_dout[0];
      if (ctl_wr && bus.cpu_dout[1]) begin
        tmr_cnt  <= 16'd0;
        nmi_cnt  <= 8'd0;
        nmireq_q <= 1'b0;
      end else begin
        tmr_cnt <= tmr_wrap ? 16'd0 : tmr_cnt + 16'd1;
        // An active pulse always runs to completion and masks any wrap that lands inside it.
        if (nmireq_q) begin
          if (nmi_cnt == 8'd0) nmireq_q <= 1'b0;
          else                 nmi_cnt  <= nmi_cnt - 8'd1;
        end else if (tmr_wrap && nmi_en) begin
          nmireq_q <= 1'b1;
          nmi_cnt  <= NMI_WIDTH - 8'd1;
        end
      end
    end
  end

  always_comb begin
    bus.cpu_din = 8'hFF;
    if (bus.ir) begin
      if (cmd_sel)      bus.cpu_din = cmd_dat;
      else if (ctl_sel) bus.cpu_din = {pending, nmi_en, overrun, 5'b0};
    end
  end

  assign bus.intreq = pending;
  assign bus.nmireq = nmireq_q;

endmodule
